spi_wb_sequencer: RTL and testbench

//  Wishbone master that runs one complete SPI word transfer per request on the 3-bit-address SPI wrapper core.

---
 rtl/spi_wb_sequencer.sv | 171 +++++++++++++++++
 tb/tb_spi_wb_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_sequencer.sv
// spi_wb_sequencer: Wishbone master that runs one SPI word transfer per request on the SPI wrapper core.
// Define SPI_SEQ_TIMEOUT_EN to bound CTRL polling with POLL_TIMEOUT and report a timeout as an error.
module spi_wb_sequencer #(
  parameter logic [7:0] SS_MASK   = 8'h01,
  parameter bit         LSB_FIRST = 1'b0
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned POLL_TIMEOUT = 1023
`endif
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_data_i,
  input  logic [4:0]  req_len_i,
  input  logic [15:0] req_div_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic [2:0]  m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 5;

  localparam logic [2:0] ADR_TX   = 3'd0;
  localparam logic [2:0] ADR_CTRL = 3'd4;
  localparam logic [2:0] ADR_DIV  = 3'd5;
  localparam logic [2:0] ADR_SS   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_CTRL, S_POLL, S_RD_RX, S_RESP
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_q;
  logic [LEN_W-1:0]    len_q;
  logic [6:0]          char_len_c;
  logic [DATA_W-1:0]   ctrl_word_c;
  logic [DATA_W-1:0]   rx_mask_c;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [9:0] POLL_LIMIT = 10'(POLL_TIMEOUT);
  logic [9:0] poll_cnt;
`endif

  // CTRL word: ASS, TX_NEG and GO set; a zero length encodes a full 32-bit word
  always_comb begin
    char_len_c  = (len_q == 5'd0) ? 7'd32 : {2'b00, len_q};
    ctrl_word_c = {18'd0, 1'b1, 1'b0, LSB_FIRST, 1'b1, 1'b0, 1'b1, 1'b0, char_len_c};
    rx_mask_c   = (len_q == 5'd0) ? {DATA_W{1'b1}} : ((32'd1 << len_q) - 32'd1);
  end

  assign m_wb_stb_o = m_wb_cyc_o;
  assign m_wb_sel_o = 4'hF;

  // Each access state first raises cyc (one idle cycle after the previous ack), then waits for ack/err
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_data_o  <= '0;
      m_wb_cyc_o   <= 1'b0;
      m_wb_we_o    <= 1'b0;
      m_wb_adr_o   <= '0;
      m_wb_dat_o   <= '0;
      data_q       <= '0;
      len_q        <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      poll_cnt     <= '0;
`endif
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            data_q      <= req_data_i;
            len_q       <= req_len_i;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            m_wb_we_o   <= 1'b1;
            m_wb_adr_o  <= ADR_DIV;
            m_wb_dat_o  <= {16'd0, req_div_i};
            state       <= S_WR_DIV;
          end
        end
        S_RESP: begin
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          if (!m_wb_cyc_o) begin
            m_wb_cyc_o <= 1'b1;
          end else if (m_wb_err_i) begin
            m_wb_cyc_o   <= 1'b0;
            m_wb_we_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            state        <= S_RESP;
          end else if (m_wb_ack_i) begin
            m_wb_cyc_o <= 1'b0;
            case (state)
              S_WR_DIV: begin
                m_wb_adr_o <= ADR_SS;
                m_wb_dat_o <= {24'd0, SS_MASK};
                state      <= S_WR_SS;
              end
              S_WR_SS: begin
                m_wb_adr_o <= ADR_TX;
                m_wb_dat_o <= data_q;
                state      <= S_WR_TX;
              end
              S_WR_TX: begin
                m_wb_adr_o <= ADR_CTRL;
                m_wb_dat_o <= ctrl_word_c;
                state      <= S_WR_CTRL;
              end
              S_WR_CTRL: begin
                m_wb_we_o  <= 1'b0;
                m_wb_adr_o <= ADR_CTRL;
                m_wb_dat_o <= '0;
                state      <= S_POLL;
`ifdef SPI_SEQ_TIMEOUT_EN
                poll_cnt   <= '0;
`endif
              end
              S_POLL: begin
                if (m_wb_dat_i[8]) begin
`ifdef SPI_SEQ_TIMEOUT_EN
                  if (poll_cnt + 10'd1 == POLL_LIMIT) begin
                    resp_valid_o <= 1'b1;
                    resp_err_o   <= 1'b1;
                    state        <= S_RESP;
                  end else begin
                    poll_cnt <= poll_cnt + 10'd1;
                  end
`endif
                end else begin
                  m_wb_adr_o <= ADR_TX;
                  state      <= S_RD_RX;
                end
              end
              S_RD_RX: begin
                resp_data_o  <= m_wb_dat_i & rx_mask_c;
                resp_valid_o <= 1'b1;
                resp_err_o   <= 1'b0;
                state        <= S_RESP;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// tb_spi_wb_sequencer: table-driven and randomized bench for spi_wb_sequencer with a behavioural SPI core model.
// Build with SPI_SEQ_TIMEOUT_EN defined to also exercise the poll timeout (POLL_TIMEOUT=3).
module tb_spi_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [4:0]  req_len = '0;
  logic [15:0] req_div = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [2:0]  wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  always #5 clk = ~clk;

  spi_wb_sequencer #(
    .SS_MASK(8'h01),
    .LSB_FIRST(1'b0)
`ifdef SPI_SEQ_TIMEOUT_EN
    , .POLL_TIMEOUT(3)
`endif
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .req_len_i(req_len), .req_div_i(req_div),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err), .busy_o(busy),
    .m_wb_adr_o(wb_adr), .m_wb_dat_o(wb_dat_o), .m_wb_dat_i(wb_dat_i), .m_wb_sel_o(wb_sel),
    .m_wb_we_o(wb_we), .m_wb_cyc_o(wb_cyc), .m_wb_stb_o(wb_stb),
    .m_wb_ack_i(wb_ack), .m_wb_err_i(wb_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- SPI core slave model ----------------
  logic [31:0] slv_rx = '0;
  int          slv_polls = 0;
  int          slv_err_at = -1;
  bit          slv_both = 1'b0;
  int          slv_lat = 0;
  int          acc_n = 0;
  int          polls_left = 0;
  int          lat_cnt = 0;
  logic [35:0] log_q [0:63];

  always @(posedge clk) begin
    wb_ack <= 1'b0;
    wb_err <= 1'b0;
    if (req_valid && req_ready) begin
      acc_n      <= 0;
      polls_left <= slv_polls;
      lat_cnt    <= 0;
    end else if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
      if (lat_cnt < slv_lat) begin
        lat_cnt <= lat_cnt + 1;
      end else begin
        lat_cnt <= 0;
        if (acc_n == slv_err_at) begin
          wb_err <= 1'b1;
          wb_ack <= slv_both;
        end else begin
          wb_ack <= 1'b1;
        end
        if (acc_n < 64) log_q[6'(acc_n)] <= {wb_we, wb_adr, wb_we ? wb_dat_o : 32'h0};
        acc_n <= acc_n + 1;
        if (!wb_we) begin
          if (wb_adr == 3'd4) begin
            if (polls_left > 0) begin
              wb_dat_i   <= $urandom | 32'h100;
              polls_left <= polls_left - 1;
            end else begin
              wb_dat_i <= $urandom & ~32'h100;
            end
          end else begin
            wb_dat_i <= slv_rx;
          end
        end
      end
    end
  end

  // ---------------- bus/handshake protocol monitor ----------------
  bit          mon_en = 1'b0;
  int          prot_err = 0;
  int          n_accepts = 0;
  logic        ack_d = 1'b0, cyc_d = 1'b0, resp_d = 1'b0;
  logic [35:0] hold_d = '0;

  always @(posedge clk) if (!rst && req_valid && req_ready) n_accepts <= n_accepts + 1;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      ack_d <= 1'b0; cyc_d <= 1'b0; resp_d <= 1'b0;
    end else begin
      if (wb_stb !== wb_cyc || wb_sel !== 4'hF) begin prot_err <= prot_err + 1; $display("protocol: stb/sel"); end
      if (req_ready !== !busy) begin prot_err <= prot_err + 1; $display("protocol: ready/busy"); end
      if (resp_valid && (req_ready || resp_d)) begin prot_err <= prot_err + 1; $display("protocol: resp pulse"); end
      if (ack_d && wb_cyc) begin prot_err <= prot_err + 1; $display("protocol: no idle cycle after ack"); end
      if (cyc_d && wb_cyc && !ack_d && {wb_we, wb_adr, wb_dat_o} !== hold_d) begin
        prot_err <= prot_err + 1; $display("protocol: access changed before ack");
      end
      ack_d  <= wb_ack | wb_err;
      cyc_d  <= wb_cyc;
      resp_d <= resp_valid;
      hold_d <= {wb_we, wb_adr, wb_dat_o};
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [4:0]  len;
    logic [15:0] div;
    logic [31:0] rx;
    int          polls;
    int          err_at;
    bit          both;
    int          lat;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_resp;
    bit          exp_err;
    int          exp_nacc;
  } txn_t;

  function automatic txn_t mk(input logic [31:0] d, input logic [4:0] l, input logic [15:0] dv,
                              input logic [31:0] rx, input int polls, input int err_at, input bit both,
                              input int lat, input logic [31:0] ectrl, input logic [31:0] eresp,
                              input bit eerr, input int enacc);
    txn_t t;
    t.data = d; t.len = l; t.div = dv; t.rx = rx; t.polls = polls; t.err_at = err_at;
    t.both = both; t.lat = lat; t.exp_ctrl = ectrl; t.exp_resp = eresp; t.exp_err = eerr;
    t.exp_nacc = enacc;
    return t;
  endfunction

  function automatic logic [31:0] model_ctrl(input logic [4:0] len);
    int unsigned n;
    n = (len == 5'd0) ? 32 : int'(len);
    return 32'h2000 + 32'h0400 + 32'h0100 + 32'(n);
  endfunction

  function automatic logic [31:0] model_resp(input logic [31:0] rx, input logic [4:0] len);
    longint unsigned m;
    m = (len == 5'd0) ? 64'h1_0000_0000 : (64'd1 << len);
    return 32'({32'd0, rx} % m);
  endfunction

  // Expected k-th bus access: four writes, polls+1 CTRL reads, one RX0 read
  function automatic logic [35:0] model_access(input txn_t t, input int i);
    if (i == 0) return {1'b1, 3'd5, 16'd0, t.div};
    if (i == 1) return {1'b1, 3'd6, 32'h1};
    if (i == 2) return {1'b1, 3'd0, t.data};
    if (i == 3) return {1'b1, 3'd4, t.exp_ctrl};
    if (i < 5 + t.polls) return {1'b0, 3'd4, 32'd0};
    return {1'b0, 3'd0, 32'd0};
  endfunction

  task automatic do_txn(input txn_t t, input string tag);
    int cyc_n;
    slv_rx = t.rx; slv_polls = t.polls; slv_err_at = t.err_at; slv_both = t.both; slv_lat = t.lat;
    chk($sformatf("%s ready", tag), req_ready, 1'b1);
    req_valid = 1'b1; req_data = t.data; req_len = t.len; req_div = t.div;
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = $urandom; req_len = 5'($urandom); req_div = 16'($urandom);
    cyc_n = 0;
    while (!resp_valid && cyc_n < 3000) begin
      @(posedge clk); #1;
      cyc_n++;
    end
    chk($sformatf("%s resp_valid", tag), resp_valid, 1'b1);
    if (resp_valid) begin
      chk($sformatf("%s resp_err", tag), resp_err, t.exp_err);
      chk($sformatf("%s resp_data", tag), resp_data, t.exp_resp);
      chk($sformatf("%s access count", tag), acc_n, t.exp_nacc);
      for (int i = 0; i < t.exp_nacc && i < acc_n && i < 64; i++)
        chk($sformatf("%s access %0d", tag, i), log_q[i], model_access(t, i));
      @(posedge clk); #1;
      chk($sformatf("%s resp pulse end", tag), resp_valid, 1'b0);
      chk($sformatf("%s ready back", tag), req_ready, 1'b1);
    end
  endtask

  txn_t        tbl [8];
  txn_t        t;
  logic [31:0] last_good;

  initial begin
    int acc0, nresp, cyc_n, seen;
    // data, len, div, rx, polls, err_at, both, lat, exp_ctrl, exp_resp, exp_err, exp_nacc
    tbl[0] = mk(32'h0000_00A5, 5'd8,  16'd4,      32'h1234_56C3, 2, -1, 0, 0, 32'h2508, 32'h0000_00C3, 0, 8);
    tbl[1] = mk(32'hDEAD_BEEF, 5'd0,  16'h0010,   32'hCAFE_F00D, 0, -1, 0, 1, 32'h2520, 32'hCAFE_F00D, 0, 6);
    tbl[2] = mk(32'h0000_03FF, 5'd1,  16'hFFFF,   32'hFFFF_FFFF, 1, -1, 0, 2, 32'h2501, 32'h0000_0001, 0, 7);
    tbl[3] = mk(32'h0000_0007, 5'd31, 16'd1,      32'hFFFF_FFFF, 0, -1, 0, 0, 32'h251F, 32'h7FFF_FFFF, 0, 6);
    tbl[4] = mk(32'h0000_0055, 5'd8,  16'd2,      32'h1111_1111, 0,  1, 0, 0, 32'h2508, 32'h7FFF_FFFF, 1, 2);
    tbl[5] = mk(32'h0000_0066, 5'd8,  16'd2,      32'h2222_2222, 3,  5, 0, 1, 32'h2508, 32'h7FFF_FFFF, 1, 6);
    tbl[6] = mk(32'h0000_0077, 5'd8,  16'd2,      32'h3333_3333, 0,  5, 0, 0, 32'h2508, 32'h7FFF_FFFF, 1, 6);
    tbl[7] = mk(32'h0000_0088, 5'd8,  16'd2,      32'h4444_4444, 0,  2, 1, 0, 32'h2508, 32'h7FFF_FFFF, 1, 3);

    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset resp_valid", resp_valid, 1'b0);
    chk("reset resp_err", resp_err, 1'b0);
    chk("reset resp_data", resp_data, 32'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset cyc/stb/we", {wb_cyc, wb_stb, wb_we}, 3'b000);
    chk("reset adr", wb_adr, 3'd0);
    chk("reset dat_o", wb_dat_o, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) do_txn(tbl[k], $sformatf("vec%0d", k));
    last_good = 32'h7FFF_FFFF;

    for (int k = 0; k < 20; k++) begin
      t = mk($urandom, 5'($urandom), 16'($urandom), $urandom, $urandom_range(0, 3), -1, 0,
             $urandom_range(0, 2), 32'h0, 32'h0, 0, 0);
      t.exp_ctrl = model_ctrl(t.len);
      t.exp_resp = model_resp(t.rx, t.len);
      t.exp_nacc = 6 + t.polls;
      do_txn(t, $sformatf("rand%0d", k));
      last_good = t.exp_resp;
    end

    // Request held high across several transfers: one accept per response
    slv_rx = 32'hA1B2_C3D4; slv_polls = 1; slv_err_at = -1; slv_both = 0; slv_lat = 0;
    acc0 = n_accepts; nresp = 0; cyc_n = 0;
    req_valid = 1'b1; req_data = 32'h0000_5A5A; req_len = 5'd16; req_div = 16'd3;
    while (nresp < 3 && cyc_n < 2000) begin
      @(posedge clk); #1;
      cyc_n++;
      if (resp_valid) begin
        nresp++;
        chk($sformatf("held resp%0d data", nresp), resp_data, 32'h0000_C3D4);
        chk($sformatf("held resp%0d err", nresp), resp_err, 1'b0);
        if (nresp == 3) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("held responses", nresp, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("held accepts", n_accepts - acc0, 3);
    last_good = 32'h0000_C3D4;

`ifdef SPI_SEQ_TIMEOUT_EN
    do_txn(mk(32'h12, 5'd8, 16'd1, 32'h0, 1000000, -1, 0, 0, 32'h2508, last_good, 1, 7), "timeout");
`endif

    // Reset in the middle of the poll phase aborts without a response
    slv_rx = 32'h0; slv_polls = 50; slv_err_at = -1; slv_both = 0; slv_lat = 0;
    req_valid = 1'b1; req_data = 32'h0000_00F0; req_len = 5'd8; req_div = 16'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc_n = 0;
    while ((acc_n < 6 || !wb_cyc) && cyc_n < 500) begin
      @(posedge clk); #1;
      cyc_n++;
    end
    chk("midreset bus active", wb_cyc, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset cyc dropped", wb_cyc, 1'b0);
    chk("midreset ready", req_ready, 1'b1);
    chk("midreset resp_data cleared", resp_data, 32'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (resp_valid || wb_cyc) seen++;
    end
    chk("midreset quiet afterwards", seen, 0);
    do_txn(mk(32'hA5, 5'd8, 16'd4, 32'h1234_56C3, 0, -1, 0, 0, 32'h2508, 32'hC3, 0, 6), "recover");

    chk("protocol violations", prot_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
